// File: rtl/spr_file.sv
// Special-purpose register file: SR/ESR/ECA/EPC/EDATA/PTO/PTL/MODE/EMODE plus general slots,
// with interrupt entry, exception return, privileged writes and a saturating nesting counter.
module spr_file #(
  parameter int unsigned              DATA_W   = 32,
  parameter int unsigned              ADDR_W   = 4,
  parameter int unsigned              NUM_SPR  = 16,
  parameter logic [DATA_W-1:0]        NMI_MASK = DATA_W'(1),
  parameter int unsigned              DEPTH_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               jisr,
  input  logic               eret,
  input  logic               rpt,
  input  logic [DATA_W-1:0]  mca,
  input  logic [DATA_W-1:0]  pc,
  input  logic [DATA_W-1:0]  next_pc,
  input  logic [DATA_W-1:0]  ea,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  sr_out,
  output logic               mode_out,
  output logic [DATA_W-1:0]  epc_out,
  output logic [DATA_W-1:0]  pto_out,
  output logic [DATA_W-1:0]  ptl_out,
  output logic               int_req,
  output logic               priv_viol,
  output logic [DEPTH_W-1:0] depth_out
);

  localparam int unsigned IDX_SR    = 0;
  localparam int unsigned IDX_ESR   = 1;
  localparam int unsigned IDX_ECA   = 2;
  localparam int unsigned IDX_EPC   = 3;
  localparam int unsigned IDX_EDATA = 4;
  localparam int unsigned IDX_PTO   = 5;
  localparam int unsigned IDX_PTL   = 6;
  localparam int unsigned IDX_MODE  = 7;
  localparam int unsigned IDX_EMODE = 8;

  logic [DATA_W-1:0]  regs_q [NUM_SPR];
  logic [DATA_W-1:0]  regs_d [NUM_SPR];
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               mode;

  assign mode = regs_q[IDX_MODE][0];

  // Next state: jisr beats eret beats a software write; only one class applies.
  always_comb begin
    regs_d  = regs_q;
    depth_d = depth_q;
    if (jisr) begin
      regs_d[IDX_SR]    = '0;
      regs_d[IDX_ESR]   = regs_q[IDX_SR];
      regs_d[IDX_ECA]   = mca;
      regs_d[IDX_EPC]   = rpt ? pc : next_pc;
      regs_d[IDX_EDATA] = ea;
      regs_d[IDX_EMODE] = DATA_W'(regs_q[IDX_MODE][0]);
      regs_d[IDX_MODE]  = '0;
      if (depth_q != {DEPTH_W{1'b1}}) depth_d = depth_q + DEPTH_W'(1);
    end else if (eret) begin
      regs_d[IDX_SR]   = regs_q[IDX_ESR];
      regs_d[IDX_MODE] = DATA_W'(regs_q[IDX_EMODE][0]);
      if (depth_q != '0) depth_d = depth_q - DEPTH_W'(1);
    end else if (wr_en && !mode) begin
      for (int i = 0; i < int'(NUM_SPR); i++) begin
        if (wr_addr == ADDR_W'(i)) begin
          if (i == int'(IDX_MODE) || i == int'(IDX_EMODE)) regs_d[i] = DATA_W'(wr_data[0]);
          else                                             regs_d[i] = wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q  <= '{default: '0};
      depth_q <= '0;
    end else begin
      regs_q  <= regs_d;
      depth_q <= depth_d;
    end
  end

  // Stored-state read; out-of-range indices return zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < int'(NUM_SPR); i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
    end
  end

  assign sr_out    = regs_q[IDX_SR];
  assign mode_out  = mode;
  assign epc_out   = regs_q[IDX_EPC];
  assign pto_out   = regs_q[IDX_PTO];
  assign ptl_out   = regs_q[IDX_PTL];
  assign depth_out = depth_q;
  assign int_req   = |(mca & (regs_q[IDX_SR] | NMI_MASK));
  assign priv_viol = wr_en & mode & ~jisr & ~eret;

endmodule
